// File: rtl/stack_control_pkg.sv
// Shared widths, defaults and decode types for the stack front end.
package stack_control_pkg;

    localparam int unsigned SP_WIDTH            = 8;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 4;
    localparam int unsigned DEFAULT_STACK_DEPTH = 16;

    // Operation chosen for the current cycle from the edge pulses
    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_PUSH   = 2'd1,
        OP_POP    = 2'd2,
        OP_BROWSE = 2'd3
    } stack_op_e;

    // Next browse position: walk downwards and wrap from the bottom entry to the top
    function automatic logic [SP_WIDTH-1:0] browse_next(
        input logic [SP_WIDTH-1:0] rd_idx,
        input logic [SP_WIDTH-1:0] sp
    );
        return (rd_idx == '0) ? (sp - SP_WIDTH'(1)) : (rd_idx - SP_WIDTH'(1));
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button plus a registered rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_meta;
    logic sync_q;
    logic sync_d;

    // Synchronize, delay one more cycle, and register the rise as a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            sync_d    <= 1'b0;
            pulse     <= 1'b0;
        end else begin
            sync_meta <= btn;
            sync_q    <= sync_meta;
            sync_d    <= sync_q;
            pulse     <= sync_q & ~sync_d;
        end
    end

endmodule

// File: rtl/stack_control.sv
// Stack front end: button conditioning, storage, stack pointer and read-more browsing.
module stack_control
    import stack_control_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_btn,
    input  logic                  pop_btn,
    input  logic                  read_more_btn,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  push_edge,
    output logic                  pop_edge,
    output logic                  read_more_edge,
    output logic                  stack_push,
    output logic                  stack_pop,
    output logic                  citajVise,
    output logic [SP_WIDTH-1:0]   sp,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_WIDTH-1:0] DEPTH_SP = SP_WIDTH'(STACK_DEPTH);

    logic [DATA_WIDTH-1:0] mem [STACK_DEPTH];
    logic [SP_WIDTH-1:0]   rd_idx;

    stack_op_e             op_c;
    logic [SP_WIDTH-1:0]   top_idx_c;
    logic [SP_WIDTH-1:0]   browse_idx_c;
    logic [DATA_WIDTH-1:0] top_data_c;
    logic [DATA_WIDTH-1:0] browse_data_c;

    // Button conditioning: one synchronizer and edge detector per button
    btn_edge_sync u_push_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (push_btn),
        .pulse (push_edge)
    );

    btn_edge_sync u_pop_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (pop_btn),
        .pulse (pop_edge)
    );

    btn_edge_sync u_read_more_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (read_more_btn),
        .pulse (read_more_edge)
    );

    // Decide this cycle's operation; simultaneous push/pop cancel and any push/pop masks read-more
    always_comb begin
        op_c = OP_NONE;
        if (push_edge && !pop_edge) begin
            if (sp != DEPTH_SP) begin
                op_c = OP_PUSH;
            end
        end else if (pop_edge && !push_edge) begin
            if (sp != '0) begin
                op_c = OP_POP;
            end
        end else if (read_more_edge && !push_edge && !pop_edge) begin
            op_c = OP_BROWSE;
        end
    end

    // Combinational storage reads for the top entry and the next browse entry
    always_comb begin
        top_idx_c     = sp - SP_WIDTH'(1);
        browse_idx_c  = citajVise ? browse_next(rd_idx, sp) : top_idx_c;
        top_data_c    = mem[IDX_W'(top_idx_c)];
        browse_data_c = mem[IDX_W'(browse_idx_c)];
    end

    // Storage write on an accepted push; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (op_c == OP_PUSH) begin
            mem[IDX_W'(sp)] <= data_in;
        end
    end

    // Stack pointer, strobes, browse state and data output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp         <= '0;
            stack_push <= 1'b0;
            stack_pop  <= 1'b0;
            citajVise  <= 1'b0;
            rd_idx     <= '0;
            data_out   <= '0;
        end else begin
            stack_push <= (op_c == OP_PUSH);
            stack_pop  <= (op_c == OP_POP);
            case (op_c)
                OP_PUSH: begin
                    sp        <= sp + SP_WIDTH'(1);
                    citajVise <= 1'b0;
                end
                OP_POP: begin
                    sp        <= top_idx_c;
                    data_out  <= top_data_c;
                    citajVise <= 1'b0;
                end
                OP_BROWSE: begin
                    citajVise <= 1'b1;
                    if (sp != '0) begin
                        rd_idx   <= browse_idx_c;
                        data_out <= browse_data_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_control.sv
// Scoreboard bench for stack_control: stimulus queues expected output cycles, a monitor checks them.
module tb_stack_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push_btn = 1'b0;
    logic       pop_btn = 1'b0;
    logic       read_more_btn = 1'b0;
    logic [3:0] data_in = 4'h0;
    logic       push_edge;
    logic       pop_edge;
    logic       read_more_edge;
    logic       stack_push;
    logic       stack_pop;
    logic       citajVise;
    logic [7:0] sp;
    logic [3:0] data_out;

    stack_control #(
        .DATA_WIDTH  (4),
        .STACK_DEPTH (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_btn       (push_btn),
        .pop_btn        (pop_btn),
        .read_more_btn  (read_more_btn),
        .data_in        (data_in),
        .push_edge      (push_edge),
        .pop_edge       (pop_edge),
        .read_more_edge (read_more_edge),
        .stack_push     (stack_push),
        .stack_pop      (stack_pop),
        .citajVise      (citajVise),
        .sp             (sp),
        .data_out       (data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // obs = {push_edge, pop_edge, read_more_edge, stack_push, stack_pop, citajVise, sp, data_out}
    typedef struct {
        int          id;
        int          cyc;
        logic [17:0] obs;
    } exp_t;

    typedef struct {
        int          id;
        logic [17:0] obs;
    } st_t;

    exp_t sb_q[$];
    st_t  st_q[$];

    int   n_vec = 0;
    int   n_fail = 0;
    int   vid = 0;
    logic done = 1'b0;
    logic prev_any = 1'b0;

    logic [7:0] m_sp = 8'd0;
    logic [3:0] m_dout = 4'h0;
    logic       m_cit = 1'b0;
    logic [7:0] m_idx = 8'd0;
    logic [3:0] m_mem [16];

    // Monitor: check scoreboard on every edge/strobe/decision cycle and drain idle-state checks
    always @(negedge clk) begin
        logic [17:0] obs;
        logic        act;
        exp_t        e;
        st_t         s;
        obs = {push_edge, pop_edge, read_more_edge, stack_push, stack_pop, citajVise, sp, data_out};
        if (!rst_n) begin
            prev_any = 1'b0;
        end else begin
            act = push_edge | pop_edge | read_more_edge | stack_push | stack_pop | prev_any;
            prev_any = push_edge | pop_edge | read_more_edge;
            if (act) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output cycle %0d got obs %h, required no activity", cyc, obs);
                end else begin
                    e = sb_q.pop_front();
                    if (e.obs !== obs || e.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL vec%0d got cycle %0d obs %h, required cycle %0d obs %h",
                                 e.id, cyc, obs, e.cyc, e.obs);
                    end
                end
            end
        end
        while (st_q.size() != 0) begin
            s = st_q.pop_front();
            n_vec++;
            if (s.obs !== obs) begin
                n_fail++;
                $display("FAIL state%0d got obs %h, required obs %h", s.id, obs, s.obs);
            end
        end
        if (done) begin
            n_vec++;
            if (sb_q.size() != 0) begin
                n_fail++;
                $display("FAIL sb_drain got %0d pending, required 0", sb_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
            $finish;
        end
    end

    // Idle-state expectation (no pulses) checked at the next falling edge
    task automatic expect_state(input int id, input logic [7:0] esp, input logic [3:0] edout,
                                input logic ecit);
        st_t s;
        s.id  = id;
        s.obs = {5'b00000, ecit, esp, edout};
        st_q.push_back(s);
    endtask

    // One button press: queue the edge cycle and the decision cycle, then drive and release
    task automatic press(input logic p, input logic q, input logic r, input logic [3:0] din);
        exp_t e;
        int   c;
        logic spush;
        logic spop;
        @(posedge clk);
        #2;
        c     = cyc;
        e.id  = vid;
        e.cyc = c + 3;
        e.obs = {p, q, r, 2'b00, m_cit, m_sp, m_dout};
        sb_q.push_back(e);
        vid++;
        spush = 1'b0;
        spop  = 1'b0;
        if (p && !q) begin
            if (m_sp < 8'd16) begin
                m_mem[m_sp[3:0]] = din;
                m_sp  = m_sp + 8'd1;
                m_cit = 1'b0;
                spush = 1'b1;
            end
        end else if (q && !p) begin
            if (m_sp > 8'd0) begin
                m_sp   = m_sp - 8'd1;
                m_dout = m_mem[m_sp[3:0]];
                m_cit  = 1'b0;
                spop   = 1'b1;
            end
        end else if (r && !p && !q) begin
            if (m_sp != 8'd0) begin
                if (!m_cit) m_idx = m_sp - 8'd1;
                else if (m_idx == 8'd0) m_idx = m_sp - 8'd1;
                else m_idx = m_idx - 8'd1;
                m_dout = m_mem[m_idx[3:0]];
            end
            m_cit = 1'b1;
        end
        e.id  = vid;
        e.cyc = c + 4;
        e.obs = {3'b000, spush, spop, m_cit, m_sp, m_dout};
        sb_q.push_back(e);
        vid++;
        push_btn      = p;
        pop_btn       = q;
        read_more_btn = r;
        data_in       = din;
        repeat (5) @(posedge clk);
        #2;
        push_btn      = 1'b0;
        pop_btn       = 1'b0;
        read_more_btn = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required $finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   c;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        expect_state(0, 8'd0, 4'h0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Push 3, 7, 9
        press(1'b1, 1'b0, 1'b0, 4'd3);
        press(1'b1, 1'b0, 1'b0, 4'd7);
        press(1'b1, 1'b0, 1'b0, 4'd9);
        expect_state(1, 8'd3, 4'h0, 1'b0);

        // Pop twice: 9 then 7
        press(1'b0, 1'b1, 1'b0, 4'd0);
        press(1'b0, 1'b1, 1'b0, 4'd0);
        expect_state(2, 8'd1, 4'd7, 1'b0);

        // Fill to full, then a rejected push
        for (int i = 1; i <= 15; i++) press(1'b1, 1'b0, 1'b0, 4'(i));
        expect_state(3, 8'd16, 4'd7, 1'b0);
        press(1'b1, 1'b0, 1'b0, 4'h0);
        expect_state(4, 8'd16, 4'd7, 1'b0);

        // Drain to empty; the bottom entry still holds 3
        for (int i = 0; i < 16; i++) press(1'b0, 1'b1, 1'b0, 4'd0);
        expect_state(5, 8'd0, 4'd3, 1'b0);
        press(1'b0, 1'b1, 1'b0, 4'd0);
        expect_state(6, 8'd0, 4'd3, 1'b0);

        // Browse 3, 7, 9: expect 9, 7, 3, 9 (wrap)
        press(1'b1, 1'b0, 1'b0, 4'd3);
        press(1'b1, 1'b0, 1'b0, 4'd7);
        press(1'b1, 1'b0, 1'b0, 4'd9);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        expect_state(7, 8'd3, 4'd9, 1'b1);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        expect_state(8, 8'd3, 4'd7, 1'b1);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        expect_state(9, 8'd3, 4'd3, 1'b1);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        expect_state(10, 8'd3, 4'd9, 1'b1);
        press(1'b1, 1'b0, 1'b0, 4'd5);
        expect_state(11, 8'd4, 4'd9, 1'b0);

        // Down to sp=2 (pops 5, 9), then push/pop conflict
        press(1'b0, 1'b1, 1'b0, 4'd0);
        press(1'b0, 1'b1, 1'b0, 4'd0);
        expect_state(12, 8'd2, 4'd9, 1'b0);
        press(1'b1, 1'b1, 1'b0, 4'hA);
        expect_state(13, 8'd2, 4'd9, 1'b0);

        // Push with coincident read-more: push wins, browse ignored
        press(1'b1, 1'b0, 1'b1, 4'hB);
        expect_state(14, 8'd3, 4'd9, 1'b0);

        // Reset between the push edge pulse and its decision
        @(posedge clk);
        #2;
        c     = cyc;
        e.id  = vid;
        e.cyc = c + 3;
        e.obs = {3'b100, 2'b00, m_cit, m_sp, m_dout};
        sb_q.push_back(e);
        vid++;
        push_btn = 1'b1;
        data_in  = 4'hE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        push_btn = 1'b0;
        m_sp     = 8'd0;
        m_dout   = 4'h0;
        m_cit    = 1'b0;
        m_idx    = 8'd0;
        expect_state(15, 8'd0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Empty pop rejected after reset, then read-more at empty only sets the mode
        press(1'b0, 1'b1, 1'b0, 4'd0);
        expect_state(16, 8'd0, 4'h0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        expect_state(17, 8'd0, 4'h0, 1'b1);

        repeat (3) @(posedge clk);
        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL end_of_test got no summary, required summary line");
        $fatal(1, "monitor did not finish");
    end

endmodule

// File: doc/stack_control.md
Name: stack_control

Overview:
- Front end of the stack datapath. Conditions the three asynchronous user buttons: push, pop and read-more ("citaj vise").
- Owns the stack storage and the 8-bit stack pointer.
- Produces every input the downstream status-signal stage consumes: edge pulses, accepted-operation strobes, read-more mode flag and sp.
- Also drives the user-visible data output.

Parameters:
- DATA_WIDTH, 4, width of each stack entry.
- STACK_DEPTH, 16, number of entries. Legal range 2..255 so that sp fits 8 bits.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_btn  input  1  raw push button, asynchronous.
- pop_btn  input  1  raw pop button, asynchronous.
- read_more_btn  input  1  raw read-more button, asynchronous.
- data_in  input  DATA_WIDTH  value written on an accepted push.
- push_edge  output  1  one-cycle pulse on push button rise.
- pop_edge  output  1  one-cycle pulse on pop button rise.
- read_more_edge  output  1  one-cycle pulse on read-more button rise.
- stack_push  output  1  one-cycle strobe: push accepted.
- stack_pop  output  1  one-cycle strobe: pop accepted.
- citajVise  output  1  level: read-more browse mode active.
- sp  output  8  entry count, 0..STACK_DEPTH.
- data_out  output  DATA_WIDTH  last popped or browsed value.

Behaviour:
- Reset (rst_n low, asynchronous): all synchronizer and edge flops, sp, stack_push, stack_pop, citajVise, rd_idx and data_out go to 0. Storage array is not reset.
- Input conditioning, per button:
  - 2-flop synchronizer, then a delay flop.
  - edge = sync & ~sync_d, registered.
  - A button rising before clock edge N gives an *_edge pulse high during the cycle after edge N+2.
  - Held buttons give exactly one pulse. Glitch filtering is out of scope.
- Decision, evaluated on edge pulses in the same cycle they are high, results registered at the next clock edge:
  - push_edge & pop_edge together: conflict. Neither is accepted, no strobe, sp unchanged.
  - push_edge alone with sp < STACK_DEPTH: mem[sp] <= data_in; sp <= sp+1; stack_push pulses 1 cycle; citajVise <= 0.
  - push_edge alone with sp == STACK_DEPTH: ignored. No write, no strobe, sp holds.
  - pop_edge alone with sp > 0: data_out <= mem[sp-1]; sp <= sp-1; stack_pop pulses 1 cycle; citajVise <= 0.
  - pop_edge alone with sp == 0: ignored. data_out holds.
  - read_more_edge with no push/pop edge in the same cycle:
    - If citajVise==0: citajVise <= 1; rd_idx <= sp-1; data_out <= mem[sp-1].
    - If citajVise==1: rd_idx <= (rd_idx==0) ? sp-1 : rd_idx-1; data_out <= mem[new rd_idx]. This wraps from the bottom back to the top.
    - If sp==0: citajVise <= 1; data_out and rd_idx hold.
  - read_more_edge coinciding with any push/pop edge: ignored.
- sp arithmetic: 8-bit unsigned. It never wraps; the guards above enforce this.
- Storage read: combinational array read, registered into data_out. Zero extra latency beyond the decision cycle.
- Edge outputs are always forwarded, even when the operation is rejected. This lets the status stage flag errors on full-push and empty-pop.

Decomposition:
- Shared package/header holds:
  - SP_WIDTH = 8.
  - Default DATA_WIDTH and STACK_DEPTH.
- One natural sub-module: btn_edge_sync (2-flop synchronizer + rising-edge pulse), instantiated three times.
- Storage array and sp/browse logic stay in stack_control.

Test Plan (DATA_WIDTH=4, STACK_DEPTH=16):
- Reset, then push 3, 7, 9 (one press each) -> stack_push pulses 3 times, 1 cycle each; sp=3; push_edge pulses appear 3 cycles after each press.
- From sp=3, pop twice -> data_out 9 then 7; sp=1; stack_pop pulses twice.
- Fill to sp=16, press push again -> push_edge pulses, no stack_push, sp=16, mem unchanged. Then at sp=0 press pop -> pop_edge only, sp=0, data_out holds.
- Stack holds 3, 7, 9 with sp=3; press read_more 4 times -> citajVise=1; data_out 9, 7, 3, 9 (wrap); sp stays 3. Then push 5 -> citajVise=0, sp=4.
- Push and pop buttons rise in the same cycle with sp=2 -> both edges pulse, no strobes, sp=2.
- Assert rst_n low mid-push (between edge pulse and decision) -> sp=0, all outputs 0 immediately. After release, pop at sp=0 is rejected.
